// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target port with a small RX FIFO and a TX holding register.
// SPI pins are oversampled in clk_sys_i; all state lives in the system clock domain.
module spi_target #(
    parameter int unsigned RxDepth  = 4,
    parameter logic [7:0]  FillByte = 8'hFF
) (
    input  logic       clk_sys_i,
    input  logic       rst_sys_ni,
    input  logic       spi_sck_i,
    input  logic       spi_cs_ni,
    input  logic       spi_copi_i,
    output logic       spi_cipo_o,
    output logic       spi_cipo_en_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       cs_active_o,
    output logic       frame_end_o,
    output logic       rx_overflow_o,
    output logic       tx_underrun_o
);
    localparam int unsigned PtrW = $clog2(RxDepth);

    typedef enum logic {
        StIdle,
        StActive
    } state_t;

    state_t        state;
    logic [2:0]    sck_q;
    logic [2:0]    cs_q;
    logic [1:0]    copi_q;
    logic          sck_rise;
    logic          sck_fall;
    logic          cs_fall;
    logic          cs_rise;
    logic          copi_sync;
    logic [2:0]    bit_cnt;
    logic [6:0]    rx_shift;
    logic [7:0]    tx_shift;
    logic [7:0]    hold_data;
    logic          hold_full;
    logic [7:0]    next_tx;
    logic          tx_take;
    logic          byte_done;
    logic          rx_pop;
    logic          rx_full;
    logic          rx_push;
    logic [PtrW:0] wr_ptr;
    logic [PtrW:0] rd_ptr;
    logic [7:0]    mem [RxDepth];

    // CS syncs reset to the idle (high) level so release never looks like an edge.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sck_q  <= 3'b000;
            cs_q   <= 3'b111;
            copi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], spi_sck_i};
            cs_q   <= {cs_q[1:0], spi_cs_ni};
            copi_q <= {copi_q[0], spi_copi_i};
        end
    end

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign copi_sync = copi_q[1];

    // CS rising wins over a coincident SCK edge, so the final SCK fall of a
    // frame never pulls another TX byte.
    assign tx_take = ((state == StIdle) & cs_fall)
                   | ((state == StActive) & ~cs_rise & sck_fall
                      & (bit_cnt == 3'd0));
    assign byte_done = (state == StActive) & ~cs_rise & sck_rise
                     & (bit_cnt == 3'd7);
    assign next_tx = hold_full ? hold_data : FillByte;

    assign tx_ready_o = ~hold_full;
    assign rx_valid_o = (wr_ptr != rd_ptr);
    assign rx_full    = (wr_ptr[PtrW] != rd_ptr[PtrW])
                      && (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
    assign rx_pop     = rx_valid_o & rx_ready_i;
    assign rx_push    = byte_done & (~rx_full | rx_pop);
    assign rx_data_o  = mem[rd_ptr[PtrW-1:0]];
    assign spi_cipo_o = tx_shift[7];

    // Holding register: a load into an empty register coincident with a take
    // leaves it full because the take already used FillByte.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            hold_data <= 8'h00;
            hold_full <= 1'b0;
        end else if (tx_valid_i && !hold_full) begin
            hold_data <= tx_data_i;
            hold_full <= 1'b1;
        end else if (tx_take) begin
            hold_full <= 1'b0;
        end
    end

    // RX FIFO storage and pointers; full+pop+push overwrites the popped slot.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < RxDepth; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (rx_push) begin
                mem[wr_ptr[PtrW-1:0]] <= {rx_shift, copi_sync};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Frame FSM: shift registers, bit counter and the one-cycle status pulses.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state         <= StIdle;
            bit_cnt       <= 3'd0;
            rx_shift      <= 7'd0;
            tx_shift      <= 8'd0;
            cs_active_o   <= 1'b0;
            spi_cipo_en_o <= 1'b0;
            frame_end_o   <= 1'b0;
            rx_overflow_o <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            frame_end_o   <= 1'b0;
            rx_overflow_o <= 1'b0;
            tx_underrun_o <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cs_fall) begin
                        state         <= StActive;
                        cs_active_o   <= 1'b1;
                        spi_cipo_en_o <= 1'b1;
                        bit_cnt       <= 3'd0;
                        tx_shift      <= next_tx;
                        tx_underrun_o <= ~hold_full;
                    end
                end
                StActive: begin
                    if (cs_rise) begin
                        state         <= StIdle;
                        cs_active_o   <= 1'b0;
                        spi_cipo_en_o <= 1'b0;
                        frame_end_o   <= 1'b1;
                        bit_cnt       <= 3'd0;
                        tx_shift      <= 8'd0;
                    end else if (sck_rise) begin
                        rx_shift      <= {rx_shift[5:0], copi_sync};
                        bit_cnt       <= bit_cnt + 3'd1;
                        rx_overflow_o <= byte_done & rx_full & ~rx_pop;
                    end else if (sck_fall) begin
                        if (bit_cnt == 3'd0) begin
                            tx_shift      <= next_tx;
                            tx_underrun_o <= ~hold_full;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed SPI frames against a transaction-level model of
// the target (expected RX queue, TX holding byte, pulse counts).
module tb_spi_target;
    localparam int Depth = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       copi = 1'b0;
    logic       cipo;
    logic       cipo_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       cs_active;
    logic       frame_end;
    logic       ovf;
    logic       udr;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] hold_m = 8'h00;
    bit         hold_full_m = 1'b0;
    logic [7:0] cur_tx = 8'h00;
    int exp_uf = 0, exp_of = 0, exp_fe = 0;
    int got_uf = 0, got_of = 0, got_fe = 0;
    int uf0, of0, fe0;

    always #5 clk = ~clk;

    spi_target #(.RxDepth(Depth), .FillByte(8'hFF)) dut (
        .clk_sys_i    (clk),
        .rst_sys_ni   (rst_n),
        .spi_sck_i    (sck),
        .spi_cs_ni    (cs_n),
        .spi_copi_i   (copi),
        .spi_cipo_o   (cipo),
        .spi_cipo_en_o(cipo_en),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .cs_active_o  (cs_active),
        .frame_end_o  (frame_end),
        .rx_overflow_o(ovf),
        .tx_underrun_o(udr)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Compare process: counts pulses and checks every popped byte.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (frame_end) got_fe++;
            if (ovf) got_of++;
            if (udr) got_uf++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check("rx_valid_vs_model", 32'(rx_valid), 32'(0));
                end else begin
                    check("rx_pop_data", 32'(rx_data), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic consume();
        if (hold_full_m) begin
            cur_tx = hold_m;
            hold_full_m = 1'b0;
        end else begin
            cur_tx = 8'hFF;
            exp_uf++;
        end
    endtask

    task automatic load_tx(input logic [7:0] b);
        check("tx_ready_before_load", 32'(tx_ready), 32'(1));
        tx_data = b;
        tx_valid = 1'b1;
        wait_n(1);
        tx_valid = 1'b0;
        hold_m = b;
        hold_full_m = 1'b1;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        consume();
        wait_n(2);
    endtask

    // One byte (or a partial one) at SCK = clk/8; the last bit's fall and
    // CS deassertion happen together when 'last' is set.
    task automatic send_bits(input logic [7:0] b, input int nbits,
                             input bit last, input bit pop_pulse);
        for (int k = 0; k < nbits; k++) begin
            copi = b[7-k];
            wait_n(2);
            check("cipo_bit", 32'(cipo), 32'(cur_tx[7-k]));
            sck = 1'b1;
            if (pop_pulse && k == 7) begin
                wait_n(2);
                rx_ready = 1'b1;
                wait_n(1);
                rx_ready = 1'b0;
                wait_n(1);
            end else begin
                wait_n(4);
            end
            if (k == 7) begin
                if (exp_q.size() < Depth) exp_q.push_back(b);
                else exp_of++;
            end
            sck = 1'b0;
            if (last && k == nbits - 1) begin
                cs_n = 1'b1;
                exp_fe++;
            end else if (k == 7) begin
                consume();
            end
            wait_n(2);
        end
    endtask

    task automatic checkpoint();
        check("underrun_count", 32'(got_uf), 32'(exp_uf));
        check("overflow_count", 32'(got_of), 32'(exp_of));
        check("frame_end_count", 32'(got_fe), 32'(exp_fe));
    endtask

    task automatic snap();
        uf0 = got_uf;
        of0 = got_of;
        fe0 = got_fe;
    endtask

    task automatic drain();
        int guard = 0;
        rx_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 40) begin
            wait_n(1);
            guard++;
        end
        rx_ready = 1'b0;
        wait_n(1);
        check("drain_remaining", 32'(exp_q.size()), 32'(0));
        check("rx_valid_after_drain", 32'(rx_valid), 32'(0));
    endtask

    task automatic check_reset_outputs();
        check("rst_cipo", 32'(cipo), 32'(0));
        check("rst_cipo_en", 32'(cipo_en), 32'(0));
        check("rst_rx_data", 32'(rx_data), 32'(0));
        check("rst_rx_valid", 32'(rx_valid), 32'(0));
        check("rst_tx_ready", 32'(tx_ready), 32'(1));
        check("rst_cs_active", 32'(cs_active), 32'(0));
        check("rst_pulses", 32'({frame_end, ovf, udr}), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wait_n(3);
        check_reset_outputs();
        rst_n = 1'b1;
        wait_n(3);

        // Preloaded 3C, receive A5.
        snap();
        load_tx(8'h3C);
        check("tx_ready_held", 32'(tx_ready), 32'(0));
        cs_n = 1'b0;
        consume();
        wait_n(2);
        check("tx_ready_cs_plus2", 32'(tx_ready), 32'(0));
        wait_n(1);
        check("tx_ready_cs_plus3", 32'(tx_ready), 32'(1));
        check("cs_active_on", 32'(cs_active), 32'(1));
        check("cipo_en_on", 32'(cipo_en), 32'(1));
        send_bits(8'hA5, 8, 1'b1, 1'b0);
        wait_n(4);
        checkpoint();
        check("t1_rx_head", 32'(rx_data), 32'(8'hA5));
        check("t1_frame_end", 32'(got_fe - fe0), 32'(1));
        check("t1_underruns", 32'(got_uf - uf0), 32'(0));
        check("cs_active_off", 32'(cs_active), 32'(0));
        check("cipo_en_off", 32'(cipo_en), 32'(0));
        drain();

        // Two bytes with no TX data: two fill bytes.
        snap();
        cs_low();
        send_bits(8'h01, 8, 1'b0, 1'b0);
        send_bits(8'h02, 8, 1'b1, 1'b0);
        wait_n(4);
        checkpoint();
        check("t2_underruns", 32'(got_uf - uf0), 32'(2));
        drain();

        // Five bytes into a 4-deep FIFO with no consumer.
        snap();
        cs_low();
        for (int i = 0; i < 4; i++) send_bits(8'(8'h10 + i), 8, 1'b0, 1'b0);
        send_bits(8'h14, 8, 1'b1, 1'b0);
        wait_n(4);
        checkpoint();
        check("t3_overflows", 32'(got_of - of0), 32'(1));
        check("t3_rx_head", 32'(rx_data), 32'(8'h10));
        drain();

        // Full FIFO, pop exactly in the 5th byte's push cycle.
        snap();
        cs_low();
        for (int i = 0; i < 4; i++) send_bits(8'(8'h10 + i), 8, 1'b0, 1'b0);
        send_bits(8'h14, 8, 1'b1, 1'b1);
        wait_n(4);
        checkpoint();
        check("t4_overflows", 32'(got_of - of0), 32'(0));
        check("t4_rx_head", 32'(rx_data), 32'(8'h11));
        drain();

        // Abort after three bits, then a clean frame.
        snap();
        cs_low();
        send_bits(8'hE7, 3, 1'b1, 1'b0);
        wait_n(4);
        checkpoint();
        check("t5_no_push", 32'(rx_valid), 32'(0));
        check("t5_frame_end", 32'(got_fe - fe0), 32'(1));
        cs_low();
        send_bits(8'h5A, 8, 1'b1, 1'b0);
        wait_n(4);
        checkpoint();
        check("t5_rx_head", 32'(rx_data), 32'(8'h5A));
        drain();

        // Reset in the middle of a byte.
        load_tx(8'h77);
        cs_low();
        copi = 1'b1;
        wait_n(2);
        sck = 1'b1;
        wait_n(4);
        sck = 1'b0;
        wait_n(4);
        sck = 1'b1;
        wait_n(2);
        rst_n = 1'b0;
        wait_n(1);
        sck = 1'b0;
        cs_n = 1'b1;
        wait_n(2);
        check_reset_outputs();
        hold_full_m = 1'b0;
        snap();
        rst_n = 1'b1;
        wait_n(6);
        check("t6_no_pulses", 32'((got_fe - fe0) + (got_of - of0) + (got_uf - uf0)), 32'(0));
        check_reset_outputs();
        load_tx(8'hC3);
        cs_low();
        send_bits(8'h96, 8, 1'b1, 1'b0);
        wait_n(4);
        checkpoint();
        check("t6_rx_head", 32'(rx_data), 32'(8'h96));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
